apx_adder_pipe: RTL

Pipelined, parametrised approximate adder with a built-in error monitor. It generalises the fixed 2-bit approximate adder datapath to N-bit operands with a configurable number of approximated low bits. The approximation mode is selectable per transaction. Each result is paired with its exact sum so that absolute error, error-threshold violations and running statistics are produced in hardware. The block sits between an operand source and a result consumer, with valid/ready handshakes on both sides, and is used for on-line characterisation of approximate-adder quality.

---
 rtl/apx_adder_pipe_if.sv | 26 ++
 rtl/apx_adder_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/apx_adder_pipe_if.sv
// Operand/result handshake bundle for the pipelined approximate adder.
// The slave modport is the adder side; master is the producer/consumer side.
interface apx_adder_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic [WIDTH:0]   out_err;
    logic             out_viol;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_sum, out_err, out_viol
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_err, out_viol
    );
endinterface

// File: rtl/apx_adder_pipe.sv
// Approximate adder (exact/LOA/truncate/OR low part) with exact-sum error monitor and statistics.
// Latency: 2 cycles from input handshake to out_valid; 1 result per cycle when unstalled.
// Backpressure: two-entry skid via S1/S2; in_ready drops only when both stages hold data and out_ready is low.
module apx_adder_pipe #(
    parameter int WIDTH    = 4,
    parameter int APX_BITS = 2,
    parameter int ET       = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    apx_adder_pipe_if.slave    bus,
    input  logic               stat_clr,
    output logic [CNT_W-1:0]   stat_count,
    output logic [CNT_W-1:0]   stat_viol,
    output logic [WIDTH:0]     stat_max_err
);

    typedef enum logic [1:0] {
        MODE_EXACT = 2'b00,
        MODE_LOA   = 2'b01,
        MODE_TRUNC = 2'b10,
        MODE_OR    = 2'b11
    } mode_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        mode_e            mode;
    } op_t;

    typedef struct packed {
        logic [WIDTH:0] sum;
        logic [WIDTH:0] err;
        logic           viol;
    } res_t;

    localparam logic [WIDTH:0]   ONE_W     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   LO_MASK_W = (ONE_W << APX_BITS) - ONE_W;
    localparam logic [WIDTH-1:0] LO_MASK   = LO_MASK_W[WIDTH-1:0];
    // A threshold at or beyond the largest representable error can never be exceeded.
    localparam bit               ET_HUGE   = (ET >= (2 ** (WIDTH + 1)) - 1);
    localparam logic [WIDTH:0]   ET_V      = ET_HUGE ? '1 : (WIDTH+1)'(ET);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    op_t         s1_op;
    logic        s1_valid;
    res_t        s2_res;
    logic        s2_valid;

    logic        s1_load;
    logic        s2_load;
    logic        out_hs;

    logic        loa_cin;
    logic        hi_cin;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] lo_or;
    logic [WIDTH-1:0] lo_part;
    logic [WIDTH:0]   hi_sum;
    logic [WIDTH:0]   exact_sum;
    logic [WIDTH:0]   apx_sum;
    res_t             res_nxt;

    assign s2_load = ~s2_valid | bus.out_ready;
    assign s1_load = ~s1_valid | s2_load;
    assign out_hs  = s2_valid & bus.out_ready;

    assign bus.in_ready  = ~rst & s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.out_sum   = s2_res.sum;
    assign bus.out_err   = s2_res.err;
    assign bus.out_viol  = s2_res.viol;

    // LOA carry comes from the top approximated bit pair; absent when nothing is approximated.
    if (APX_BITS > 0) begin : g_loa_cin
        assign loa_cin = s1_op.a[APX_BITS-1] & s1_op.b[APX_BITS-1];
    end else begin : g_no_loa_cin
        assign loa_cin = 1'b0;
    end

    always_comb begin
        hi_cin    = 1'b0;
        lo_part   = '0;
        a_hi      = s1_op.a >> APX_BITS;
        b_hi      = s1_op.b >> APX_BITS;
        lo_or     = (s1_op.a | s1_op.b) & LO_MASK;
        exact_sum = {1'b0, s1_op.a} + {1'b0, s1_op.b};

        unique case (s1_op.mode)
            MODE_LOA: begin
                hi_cin  = loa_cin;
                lo_part = lo_or;
            end
            MODE_OR: begin
                lo_part = lo_or;
            end
            default: begin
                hi_cin  = 1'b0;
                lo_part = '0;
            end
        endcase

        // The high-part carry-out lands on bit WIDTH; with K == WIDTH that is hi_cin alone.
        hi_sum  = {1'b0, a_hi} + {1'b0, b_hi} + {{WIDTH{1'b0}}, hi_cin};
        apx_sum = (s1_op.mode == MODE_EXACT) ? exact_sum
                                             : ((hi_sum << APX_BITS) | {1'b0, lo_part});

        res_nxt.sum  = apx_sum;
        res_nxt.err  = (apx_sum >= exact_sum) ? (apx_sum - exact_sum) : (exact_sum - apx_sum);
        res_nxt.viol = ~ET_HUGE & (res_nxt.err > ET_V);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_op    <= '0;
            s2_res   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op <= '{a: bus.in_a, b: bus.in_b, mode: mode_e'(bus.in_mode)};
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_res <= res_nxt;
                end
            end
        end
    end

    // Clear takes priority over a coinciding delivery.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_count   <= '0;
            stat_viol    <= '0;
            stat_max_err <= '0;
        end else if (out_hs) begin
            if (stat_count != CNT_MAX) begin
                stat_count <= stat_count + 1'b1;
            end
            if (s2_res.viol && (stat_viol != CNT_MAX)) begin
                stat_viol <= stat_viol + 1'b1;
            end
            if (s2_res.err > stat_max_err) begin
                stat_max_err <= s2_res.err;
            end
        end
    end

endmodule
